// File: rtl/nonce_block_feeder.sv
// Sequencer that fetches header words 16..18 once, then sweeps a nonce range through a
// single-block SHA-256 core. Optional handshake watchdog: define NONCE_FEEDER_WDOG_EN.
module nonce_block_feeder #(
  parameter int NUM_NONCES  = 16,
  parameter int HDR_BASE    = 16,
  parameter int ADDR_W      = 16,
  parameter int WDOG_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [31:0]       nonce_base,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_read_data,
  output logic [15:0][31:0] message,
  output logic              sha_start,
  input  logic              sha_done,
  input  logic [7:0][31:0]  sha_result,
  output logic              out_valid,
  output logic [31:0]       out_nonce,
  output logic [7:0][31:0]  out_hash,
  output logic              done,
  output logic              wdog_err
);
  localparam int CNT_W = (NUM_NONCES > 1) ? $clog2(NUM_NONCES) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_RD0, S_RD1, S_RD2, S_RD3, S_FIRE, S_WBUSY, S_WDONE, S_EMIT
  } state_t;

  state_t              state, state_nxt;
  logic [31:0]         nonce_q;
  logic [31:0]         msg_nonce_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2:0][31:0]    hdr_q;
  logic                last_nonce;
  logic                wdog_trip;

  assign last_nonce = (cnt_q == CNT_W'(NUM_NONCES - 1));

`ifdef NONCE_FEEDER_WDOG_EN
  localparam int WD_W = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WD_W-1:0] wdog_cnt_q;
  logic            wdog_err_q;

  // Counter is zero in FIRE, so it equals the cycles elapsed since sha_start.
  assign wdog_trip = (state == S_WBUSY || state == S_WDONE) &&
                     (wdog_cnt_q == WD_W'(WDOG_CYCLES - 1));
  assign wdog_err  = wdog_err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wdog_cnt_q <= '0;
      wdog_err_q <= 1'b0;
    end else begin
      if (state_nxt == S_FIRE)
        wdog_cnt_q <= '0;
      else if (state == S_FIRE || state == S_WBUSY || state == S_WDONE)
        wdog_cnt_q <= wdog_cnt_q + 1'b1;
      if (wdog_trip)
        wdog_err_q <= 1'b1;
    end
  end
`else
  localparam int unused_wdog_cycles = WDOG_CYCLES;
  assign wdog_trip = 1'b0;
  assign wdog_err  = 1'b0;
`endif

  // NOTE: state and datapath registers use non-blocking assignment only; the
  // combinational block below uses blocking assignment only.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // NOTE: every combinational output gets a default before the case, so no
  // path leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = S_RD0;
      S_RD0:   state_nxt = S_RD1;
      S_RD1:   state_nxt = S_RD2;
      S_RD2:   state_nxt = S_RD3;
      S_RD3:   state_nxt = S_FIRE;
      S_FIRE:  state_nxt = S_WBUSY;
      S_WBUSY: begin
        if (wdog_trip)     state_nxt = S_IDLE;
        else if (!sha_done) state_nxt = S_WDONE;
      end
      S_WDONE: begin
        if (wdog_trip)     state_nxt = S_IDLE;
        else if (sha_done) state_nxt = S_EMIT;
      end
      S_EMIT:  state_nxt = last_nonce ? S_IDLE : S_FIRE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign done      = (state == S_IDLE);
  assign sha_start = (state == S_FIRE);
  assign out_valid = (state == S_EMIT);

  // NOTE: the three header words are a handful of flops, not a RAM, so they
  // take the async reset like the rest of the datapath.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_addr    <= '0;
      nonce_q     <= '0;
      msg_nonce_q <= '0;
      cnt_q       <= '0;
      hdr_q       <= '0;
      out_nonce   <= '0;
      out_hash    <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          nonce_q  <= nonce_base;
          cnt_q    <= '0;
          mem_addr <= ADDR_W'(HDR_BASE);
        end
        S_RD0: mem_addr <= mem_addr + 1'b1;
        S_RD1: begin
          mem_addr <= mem_addr + 1'b1;
          hdr_q[0] <= mem_read_data;
        end
        S_RD2: hdr_q[1] <= mem_read_data;
        S_RD3: begin
          hdr_q[2]    <= mem_read_data;
          msg_nonce_q <= nonce_q;
        end
        S_WDONE: if (sha_done) begin
          out_hash  <= sha_result;
          out_nonce <= nonce_q;
        end
        S_EMIT: begin
          nonce_q <= nonce_q + 32'd1;
          cnt_q   <= cnt_q + 1'b1;
          // Loading the nonce word on the way into FIRE keeps message stable FIRE to FIRE.
          if (!last_nonce) msg_nonce_q <= nonce_q + 32'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    message     = '0;
    message[0]  = hdr_q[0];
    message[1]  = hdr_q[1];
    message[2]  = hdr_q[2];
    message[3]  = msg_nonce_q;
    message[4]  = 32'h8000_0000;
    message[15] = 32'd640;
  end

endmodule

// File: tb/tb_nonce_block_feeder.sv
// Randomized self-checking bench for nonce_block_feeder: behavioural core stub, header memory,
// and a queue scoreboard of expected (nonce, digest) pairs built from the job parameters.
module tb_nonce_block_feeder;
  localparam int NN = 4;
  localparam int HB = 16;
  localparam int AW = 16;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [31:0]       nonce_base = '0;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_read_data;
  logic [15:0][31:0] message;
  logic              sha_start;
  logic              sha_done;
  logic [7:0][31:0]  sha_result;
  logic              out_valid;
  logic [31:0]       out_nonce;
  logic [7:0][31:0]  out_hash;
  logic              done;
  logic              wdog_err;

  nonce_block_feeder #(.NUM_NONCES(NN), .HDR_BASE(HB), .ADDR_W(AW), .WDOG_CYCLES(255)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .nonce_base(nonce_base),
    .mem_addr(mem_addr), .mem_read_data(mem_read_data), .message(message),
    .sha_start(sha_start), .sha_done(sha_done), .sha_result(sha_result),
    .out_valid(out_valid), .out_nonce(out_nonce), .out_hash(out_hash),
    .done(done), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] mem [64];
  always @(posedge clk) mem_read_data <= mem[mem_addr[5:0]];

  typedef struct { logic [31:0] nonce; logic [255:0] hash; } exp_t;
  exp_t        exp_q[$];
  logic [31:0] fire_q[$];
  logic [31:0] cur_hdr [3];
  bit          stall = 1'b0;
  int          done_rise_cyc = 0;
  int          emit_cnt = 0;
  int          visits [3];

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Digest function of the core stub: any well-mixed function of the block words will do.
  function automatic logic [255:0] core_fn(input logic [31:0] h0, h1, h2, n);
    logic [255:0] r;
    for (int i = 0; i < 8; i++)
      r[i*32 +: 32] = (h0 ^ (32'h0101_0101 * i)) + ({h1[15:0], h1[31:16]} ^ h2) * (i + 1)
                      + n * 32'h9E37_79B9 + i;
    return r;
  endfunction

  // Core stub: done high when idle, drops 0..3 cycles after start, stays busy 2..70 cycles.
  initial begin : core
    logic [15:0][31:0] m;
    logic [31:0]       n;
    sha_done   = 1'b1;
    sha_result = '0;
    forever begin
      @(negedge clk);
      if (sha_start) begin
        m = message;
        if (fire_q.size() == 0) check("fire_expected", 0, 1);
        else begin
          n = fire_q.pop_front();
          check("msg_nonce", m[3], n);
        end
        check("msg_hdr0", m[0], cur_hdr[0]);
        check("msg_hdr1", m[1], cur_hdr[1]);
        check("msg_hdr2", m[2], cur_hdr[2]);
        check("msg_w4", m[4], 32'h8000_0000);
        check("msg_w15", m[15], 32'd640);
        check("msg_pad_zero", {255'b0, |m[14:5]}, 0);
        repeat ($urandom_range(0, 3)) @(negedge clk);
        sha_done = 1'b0;
        while (stall) @(negedge clk);
        repeat ($urandom_range(2, 70)) @(negedge clk);
        sha_result    = core_fn(m[0], m[1], m[2], m[3]);
        sha_done      = 1'b1;
        done_rise_cyc = cyc;
      end
    end
  end

  // Output monitor: latency rules, scoreboard comparison, header address visits.
  initial begin : monitor
    logic [AW-1:0] prev_addr;
    int            last_valid_cyc;
    int            last_done_cyc;
    exp_t          e;
    prev_addr      = '0;
    last_valid_cyc = -100;
    last_done_cyc  = -100;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (mem_addr != prev_addr)
          for (int k = 0; k < 3; k++) if (mem_addr == AW'(HB + k)) visits[k]++;
        prev_addr = mem_addr;
        if (sha_start) begin
          if (last_done_cyc > last_valid_cyc) check("lat_start_to_fire", cyc - last_done_cyc, 5);
          else check("lat_valid_to_fire", cyc - last_valid_cyc, 1);
        end
        if (out_valid) begin
          emit_cnt++;
          check("lat_done_to_valid", cyc - done_rise_cyc, 1);
          if (exp_q.size() == 0) check("spurious_valid", 1, 0);
          else begin
            e = exp_q.pop_front();
            check("out_nonce", out_nonce, e.nonce);
            check("out_hash", out_hash, e.hash);
          end
          last_valid_cyc = cyc;
        end
        if (done) last_done_cyc = cyc;
      end
    end
  end

  task automatic new_header();
    for (int k = 0; k < 3; k++) begin
      cur_hdr[k]  = $urandom;
      mem[HB + k] = cur_hdr[k];
    end
  endtask

  task automatic expect_job(input logic [31:0] base);
    for (int k = 0; k < NN; k++) begin
      exp_q.push_back('{nonce: base + k, hash: core_fn(cur_hdr[0], cur_hdr[1], cur_hdr[2], base + k)});
      fire_q.push_back(base + k);
    end
  endtask

  task automatic launch(input logic [31:0] base);
    expect_job(base);
    @(negedge clk);
    start      = 1'b1;
    nonce_base = base;
    @(negedge clk);
    start      = 1'b0;
    nonce_base = $urandom;
  endtask

  task automatic wait_emits(input int target);
    int t = 0;
    while (emit_cnt < target && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    check("emit_count", emit_cnt, target);
    check("done_after_job", done, 1);
  endtask

  initial begin : driver
    int   tgt;
    int   t;
    logic [31:0] b;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    for (int k = 0; k < 3; k++) visits[k] = 0;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_done", done, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sha_start", sha_start, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_out_nonce", out_nonce, 0);
    check("rst_out_hash", out_hash, 0);
    check("rst_msg_low", message[3:0], 0);
    check("rst_msg_w15", message[15], 32'd640);
    check("rst_wdog", wdog_err, 0);
    reset_n = 1'b1;

    // Nonce wrap job; header addresses each visited once
    new_header();
    tgt = emit_cnt + NN;
    launch(32'hFFFF_FFFE);
    wait_emits(tgt);
    for (int k = 0; k < 3; k++) check("hdr_addr_visit", visits[k], 1);
    check("wrap_last_nonce", out_nonce, 32'h0000_0001);

    // Random jobs; every other one gets a start pulse while the core is busy
    for (int j = 0; j < 4; j++) begin
      new_header();
      tgt = emit_cnt + NN;
      launch($urandom);
      if (j[0]) begin
        t = 0;
        while (emit_cnt < tgt - NN + 1 && t < 500) begin @(negedge clk); t++; end
        while (sha_done && t < 600) begin @(negedge clk); t++; end
        start = 1'b1; nonce_base = $urandom;
        @(negedge clk);
        start = 1'b0;
      end
      wait_emits(tgt);
    end

    // Start held high across job end restarts a job
    new_header();
    b   = $urandom;
    tgt = emit_cnt + 2 * NN;
    expect_job(b);
    expect_job(b);
    @(negedge clk);
    start = 1'b1; nonce_base = b;
    t = 0;
    while (emit_cnt < tgt - NN && t < 2000) begin @(negedge clk); t++; end
    while (!done && t < 2100) begin @(negedge clk); t++; end
    @(negedge clk);
    check("hold_start_restart", done, 0);
    start = 1'b0;
    wait_emits(tgt);

    // Reset during WDONE of the third nonce
    new_header();
    tgt = emit_cnt + 2;
    launch($urandom);
    t = 0;
    while (emit_cnt < tgt && t < 2000) begin @(negedge clk); t++; end
    while (sha_done && t < 2100) begin @(negedge clk); t++; end
    @(negedge clk);
    reset_n = 1'b0;
    exp_q.delete();
    fire_q.delete();
    @(posedge clk); #1;
    check("abort_done", done, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_sha_start", sha_start, 0);
    check("abort_mem_addr", mem_addr, 0);
    check("abort_out_nonce", out_nonce, 0);
    check("abort_out_hash", out_hash, 0);
    check("abort_msg_low", message[3:0], 0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    tgt = emit_cnt;
    repeat (100) @(negedge clk);
    check("abort_no_valid", emit_cnt, tgt);
    t = 0;
    while (!sha_done && t < 200) begin @(negedge clk); t++; end
    tgt = emit_cnt + NN;
    launch($urandom);
    wait_emits(tgt);

`ifdef NONCE_FEEDER_WDOG_EN
    // Core stalls with done low: watchdog trips, no output
    stall = 1'b1;
    b = $urandom;
    fire_q.push_back(b);
    tgt = emit_cnt;
    @(negedge clk);
    start = 1'b1; nonce_base = b;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (!sha_start && t < 20) begin @(negedge clk); t++; end
    b = 32'(cyc);
    t = 0;
    while (!wdog_err && t < 400) begin @(negedge clk); t++; end
    check("wdog_gap", ((cyc - int'(b)) >= 255 && (cyc - int'(b)) <= 256), 1);
    check("wdog_idle", done, 1);
    repeat (5) @(negedge clk);
    check("wdog_no_valid", emit_cnt, tgt);
    stall = 1'b0;
    repeat (100) @(negedge clk);
    check("wdog_sticky", wdog_err, 1);
`else
    check("wdog_tied_low", wdog_err, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin : timeout
    #500_000;
    $display("FAIL timeout: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
